// File: rtl/hazard_stall_if.sv
// Decode/EX hazard-stall bundle between the pipeline datapath and the stall unit.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; PCWrite/IFIDWrite are the pipeline hold controls.
interface hazard_stall_if;
    logic [31:0] instrID;
    logic        memReadEX;
    logic        mulEX;
    logic        regWriteEX;
    logic [4:0]  destEX;
    logic        branchTakenEX;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEXBubble;
    logic        IFIDFlush;
    logic        stalled;
    logic [15:0] stallCycles;

    // Pipeline side: drives the decode/EX view and consumes the hold/flush controls.
    modport master (
        output instrID, memReadEX, mulEX, regWriteEX, destEX, branchTakenEX,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, stalled, stallCycles
    );

    // Stall unit side.
    modport slave (
        input  instrID, memReadEX, mulEX, regWriteEX, destEX, branchTakenEX,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, stalled, stallCycles
    );
endinterface

// File: rtl/hazard_stall.sv
// Load-use / mul-use hazard detector that freezes PC and IF/ID and bubbles ID/EX.
// Latency: stall asserted combinationally in the detect cycle, lasting exactly N cycles.
// Backpressure: holds the front end via PCWrite/IFIDWrite; a taken branch overrides and flushes.
module hazard_stall #(
    parameter int LOAD_STALL = 1,
    parameter int MUL_STALL  = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    hazard_stall_if.slave bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    localparam logic [3:0] LOAD_LEN = 4'(LOAD_STALL);
    localparam logic [3:0] MUL_LEN  = 4'(MUL_STALL);
    localparam logic [3:0] MAX_LEN  = (LOAD_LEN > MUL_LEN) ? LOAD_LEN : MUL_LEN;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        stalled_q;
    logic [15:0] stall_cycles_q;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rs;
    logic        uses_rt;
    logic        hazard;
    logic [3:0]  stall_len;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        unused_imm;

    assign op = bus.instrID[31:26];
    assign rs = bus.instrID[25:21];
    assign rt = bus.instrID[20:16];

    // Immediate/funct bits play no part in operand-use decode.
    assign unused_imm = ^bus.instrID[15:0];

    // Which source fields the decode-stage instruction actually reads.
    always_comb begin
        uses_rs = 1'b1;
        case (op)
            6'b000010, 6'b000011, 6'b001111: uses_rs = 1'b0;  // j, jal, lui
            default: ;
        endcase
        uses_rt = 1'b0;
        case (op)
            6'b000000, 6'b011100, 6'b101011, 6'b101001, 6'b101000,
            6'b000100, 6'b000101: uses_rt = 1'b1;  // R-type, mul, stores, beq/bne
            default: ;
        endcase
    end

    // A long-latency producer in EX feeds a register the decode instruction reads.
    always_comb begin
        hazard = bus.regWriteEX & (bus.memReadEX | bus.mulEX) & (bus.destEX != 5'd0) &
                 ((uses_rs & (rs == bus.destEX)) | (uses_rt & (rt == bus.destEX)));
        if (bus.memReadEX && bus.mulEX)
            stall_len = MAX_LEN;
        else if (bus.memReadEX)
            stall_len = LOAD_LEN;
        else
            stall_len = MUL_LEN;
    end

    // Pipeline controls; reset forces the free-running defaults.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!Rst) begin
            if (bus.branchTakenEX) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if ((state == STALL) || hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Stall sequencing: the detect cycle is stall cycle 1, STALL covers the remaining N-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.branchTakenEX) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end else if (state == STALL) begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1)
                state_nxt = IDLE;
        end else if (hazard) begin
            cnt_nxt   = stall_len - 4'd1;
            state_nxt = (stall_len != 4'd1) ? STALL : IDLE;
        end
    end

    // State, countdown and registered STALL decode.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            stalled_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stalled_q <= (state_nxt == STALL);
        end
    end

    // Saturating count of frozen-PC cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            stall_cycles_q <= 16'd0;
        else if (!pc_write && (stall_cycles_q != 16'hFFFF))
            stall_cycles_q <= stall_cycles_q + 16'd1;
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IFIDWrite   = ifid_write;
    assign bus.IDEXBubble  = idex_bubble;
    assign bus.IFIDFlush   = ifid_flush;
    assign bus.stalled     = stalled_q;
    assign bus.stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Bench for hazard_stall: default-parameter and wide-parameter instances driven in lockstep.
// Latency: reference model tracks remaining stall cycles per instance.
// Backpressure: n/a (checks hold/flush outputs every cycle).
module tb_hazard_stall;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    hazard_stall_if b0 ();
    hazard_stall_if b1 ();

    hazard_stall u0 (.Clk(Clk), .Rst(Rst), .bus(b0));
    hazard_stall #(.LOAD_STALL(4), .MUL_STALL(3)) u1 (.Clk(Clk), .Rst(Rst), .bus(b1));

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference state: stall cycles still owed after the current one, and the counter.
    int rem [2];
    int sc  [2];
    int lp  [2] = '{1, 4};
    int mp  [2] = '{2, 3};

    localparam logic [5:0] OP_ADD = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_MUL = 6'h1C,
                           OP_LUI = 6'h0F, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SH = 6'h29, OP_SB = 6'h28;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h1234};
    endfunction

    function automatic bit reads_rs(input logic [5:0] op);
        return !(op inside {OP_J, OP_JAL, OP_LUI});
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return op inside {OP_ADD, OP_MUL, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE};
    endfunction

    function automatic bit ref_hazard();
        logic [5:0] op;
        logic [4:0] rs, rt, d;
        op = b0.instrID[31:26];
        rs = b0.instrID[25:21];
        rt = b0.instrID[20:16];
        d  = b0.destEX;
        if (!b0.regWriteEX || !(b0.memReadEX || b0.mulEX) || d == 5'd0)
            return 1'b0;
        return (reads_rs(op) && rs == d) || (reads_rt(op) && rt == d);
    endfunction

    function automatic int nlen(input int k);
        if (b0.memReadEX && b0.mulEX)
            return (lp[k] > mp[k]) ? lp[k] : mp[k];
        return b0.memReadEX ? lp[k] : mp[k];
    endfunction

    function automatic bit stall_now(input int k);
        return !b0.branchTakenEX && (rem[k] > 0 || ref_hazard());
    endfunction

    task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_set(input int k, input logic pc, input logic ifid, input logic bub,
                             input logic fl, input logic st, input logic [15:0] scv,
                             input logic epc, input logic eifid, input logic ebub,
                             input logic efl, input logic est, input logic [15:0] esc);
        check1($sformatf("u%0d.PCWrite", k), {15'd0, pc}, {15'd0, epc});
        check1($sformatf("u%0d.IFIDWrite", k), {15'd0, ifid}, {15'd0, eifid});
        check1($sformatf("u%0d.IDEXBubble", k), {15'd0, bub}, {15'd0, ebub});
        check1($sformatf("u%0d.IFIDFlush", k), {15'd0, fl}, {15'd0, efl});
        check1($sformatf("u%0d.stalled", k), {15'd0, st}, {15'd0, est});
        check1($sformatf("u%0d.stallCycles", k), scv, esc);
    endtask

    task automatic check_model();
        bit s0, s1, br;
        s0 = stall_now(0);
        s1 = stall_now(1);
        br = b0.branchTakenEX;
        check_set(0, b0.PCWrite, b0.IFIDWrite, b0.IDEXBubble, b0.IFIDFlush, b0.stalled, b0.stallCycles,
                  !s0, !s0, br | s0, br, rem[0] > 0, 16'(sc[0]));
        check_set(1, b1.PCWrite, b1.IFIDWrite, b1.IDEXBubble, b1.IFIDFlush, b1.stalled, b1.stallCycles,
                  !s1, !s1, br | s1, br, rem[1] > 0, 16'(sc[1]));
    endtask

    task automatic check_reset_vals();
        check_set(0, b0.PCWrite, b0.IFIDWrite, b0.IDEXBubble, b0.IFIDFlush, b0.stalled, b0.stallCycles,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        check_set(1, b1.PCWrite, b1.IFIDWrite, b1.IDEXBubble, b1.IFIDFlush, b1.stalled, b1.stallCycles,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit s;
            int n;
            s = stall_now(k);
            n = nlen(k);
            if (s && sc[k] < 65535)
                sc[k]++;
            if (b0.branchTakenEX)
                rem[k] = 0;
            else if (rem[k] > 0)
                rem[k]--;
            else if (ref_hazard())
                rem[k] = n - 1;
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic mr, input logic mul, input logic rw,
                         input logic [4:0] d, input logic br);
        b0.instrID = ins; b0.memReadEX = mr; b0.mulEX = mul; b0.regWriteEX = rw;
        b0.destEX = d; b0.branchTakenEX = br;
        b1.instrID = ins; b1.memReadEX = mr; b1.mulEX = mul; b1.regWriteEX = rw;
        b1.destEX = d; b1.branchTakenEX = br;
    endtask

    // One cycle: entered at posedge+1, inputs applied, checked at negedge, model advanced at posedge.
    task automatic step(input logic [31:0] ins, input logic mr, input logic mul, input logic rw,
                        input logic [4:0] d, input logic br, input bit chk);
        drive(ins, mr, mul, rw, d, br);
        @(negedge Clk);
        if (chk)
            check_model();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            step(mk(OP_ADDI, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset pulse placed between clock edges, entered at posedge+1.
    task automatic async_reset();
        #2 Rst = 1'b1;
        #1;
        check_reset_vals();
        rem[0] = 0; rem[1] = 0; sc[0] = 0; sc[1] = 0;
        drive(mk(OP_ADDI, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2 Rst = 1'b0;
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [5:0] ops [12];
        ops = '{OP_ADD, OP_LW, OP_SW, OP_MUL, OP_LUI, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SH, OP_SB};
        rem[0] = 0; rem[1] = 0; sc[0] = 0; sc[1] = 0;
        drive(mk(OP_ADDI, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Reset state, held with a live hazard on the inputs to prove reset dominates.
        #1 Rst = 1'b1;
        #1;
        check_reset_vals();
        drive(mk(OP_ADD, 5'd8, 5'd10), 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
        #1;
        check_reset_vals();
        drive(mk(OP_ADDI, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(posedge Clk);
        #1 Rst = 1'b0;

        // lw $8 then add $9,$8,$10: one stall cycle on the default instance.
        step(mk(OP_ADD, 5'd8, 5'd10), 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        nop(5);
        check1("lw_use_count", b0.stallCycles, 16'd1);

        // No-stall cases: destination $0, and lui which reads no source.
        step(mk(OP_ADD, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        step(mk(OP_LUI, 5'd0, 5'd4), 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
        step(mk(OP_J, 5'd4, 5'd4), 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
        step(mk(OP_ADDI, 5'd2, 5'd4), 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
        step(mk(OP_ADD, 5'd4, 5'd4), 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
        check1("no_stall_count", b0.stallCycles, 16'd1);

        // mul $5 then sw $5,0($2): rt match, two stall cycles.
        step(mk(OP_SW, 5'd2, 5'd5), 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        check1("mul_use_stalled2", {15'd0, b0.stalled}, 16'd1);
        nop(5);
        check1("mul_use_count", b0.stallCycles, 16'd3);

        // Load and mul flags together: longer of the two lengths applies.
        step(mk(OP_BEQ, 5'd7, 5'd6), 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
        nop(6);

        // Taken branch in the first STALL cycle aborts the stall.
        step(mk(OP_ADD, 5'd3, 5'd1), 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
        step(mk(OP_ADD, 5'd3, 5'd1), 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
        nop(3);

        // Async reset in the middle of a stall.
        step(mk(OP_ADD, 5'd3, 5'd1), 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
        drive(mk(OP_ADD, 5'd3, 5'd1), 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
        async_reset();
        nop(2);

        // Randomised traffic with narrow register ranges so hazards are common.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 11)];
            step(mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), 1'b1);
            if (i == 300) begin
                drive(mk(OP_ADD, 5'd1, 5'd1), 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
                async_reset();
            end
        end

        // Saturation: a load-use hazard held continuously for 70000 cycles.
        async_reset();
        for (int i = 0; i < 70000; i++)
            step(mk(OP_ADD, 5'd9, 5'd9), 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        check1("sat_u0", b0.stallCycles, 16'hFFFF);
        check1("sat_u1", b1.stallCycles, 16'hFFFF);
        step(mk(OP_ADD, 5'd9, 5'd9), 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        check1("sat_hold_u0", b0.stallCycles, 16'hFFFF);
        nop(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
